fetch_stage: RTL and testbench

Instruction fetch stage of the MIPS pipeline. Holds the program counter and drives the word address of the combinational instruction memory. Each cycle it captures the returned instruction into the IF/ID pipeline register. It handles sequential advance, redirects from jump/branch resolution, pipeline stalls and flushes.

---
 rtl/fetch_stage.sv | 92 +++++++++
 tb/tb_fetch_stage.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// MIPS instruction fetch stage: PC register, instruction memory word address and IF/ID register.
// Define FETCH_PERF_CNT_EN to add the fetch/stall/flush event counters.
module fetch_stage #(
  parameter int unsigned         PC_WIDTH    = 32,
  parameter int unsigned         ADDR_SIZE   = 8,
  parameter int unsigned         INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   redirect,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  output logic [ADDR_SIZE-1:0]   addr,
  input  logic [INSTR_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]    pc,
  output logic                   if_id_valid,
  output logic [INSTR_WIDTH-1:0] if_id_instr,
  output logic [PC_WIDTH-1:0]    if_id_pc,
  output logic [PC_WIDTH-1:0]    if_id_pc_plus4
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]            fetch_cnt,
  output logic [31:0]            stall_cnt,
  output logic [31:0]            flush_cnt
`endif
);

  logic [PC_WIDTH-1:0] pc_plus4;
  logic [PC_WIDTH-1:0] pc_next;
  logic                bubble;
  logic                load;

  always_comb begin
    pc_plus4 = pc + PC_WIDTH'(4);
    bubble   = flush | redirect;
    load     = !bubble && !stall;
    pc_next  = pc;
    // Redirect beats stall; target is forced word aligned.
    if (redirect)
      pc_next = redirect_pc & ~PC_WIDTH'(3);
    else if (!stall)
      pc_next = pc_plus4;
  end

  assign addr = pc[ADDR_SIZE+1:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pc <= RESET_PC;
    else
      pc <= pc_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_valid    <= 1'b0;
      if_id_instr    <= '0;
      if_id_pc       <= '0;
      if_id_pc_plus4 <= '0;
    end else if (bubble) begin
      if_id_valid    <= 1'b0;
      if_id_instr    <= '0;
      if_id_pc       <= '0;
      if_id_pc_plus4 <= '0;
    end else if (load) begin
      if_id_valid    <= 1'b1;
      if_id_instr    <= instr;
      if_id_pc       <= pc;
      if_id_pc_plus4 <= pc_plus4;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (load)
        fetch_cnt <= fetch_cnt + 32'd1;
      if (stall && !redirect)
        stall_cnt <= stall_cnt + 32'd1;
      if (bubble)
        flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a reference model pushes expected IF/ID and PC
// state per edge into a queue; each scenario task pops and compares after the edge.
module tb_fetch_stage;

  localparam logic [31:0] RPC = 32'h0000_0040;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [7:0]  addr;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  int unsigned checks;
  int unsigned failures;

  typedef struct packed {
    logic [31:0] pc;
    logic        v;
    logic [31:0] ins;
    logic [31:0] ipc;
    logic [31:0] ip4;
  } exp_t;

  exp_t q[$];

  logic [31:0] m_pc, m_ins, m_ipc, m_ip4;
  logic        m_v;
  logic [31:0] m_fc, m_sc, m_flc;

  fetch_stage #(
    .PC_WIDTH    (32),
    .ADDR_SIZE   (8),
    .INSTR_WIDTH (32),
    .RESET_PC    (RPC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .flush          (flush),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .addr           (addr),
    .instr          (instr),
    .pc             (pc),
    .if_id_valid    (if_id_valid),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc),
    .if_id_pc_plus4 (if_id_pc_plus4)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt      (fetch_cnt),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
`endif
  );

  // Instruction memory contents: a distinct pattern per word address.
  function automatic logic [31:0] memf(input logic [7:0] a);
    return {8'hC3, a, ~a, a ^ 8'h5A};
  endfunction

  assign instr = memf(addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  task automatic model_reset();
    m_pc  = RPC;
    m_v   = 1'b0;
    m_ins = '0;
    m_ipc = '0;
    m_ip4 = '0;
    m_fc  = '0;
    m_sc  = '0;
    m_flc = '0;
    q.delete();
  endtask

  // Drive one cycle of controls, predict post-edge state, push it, step past the edge.
  task automatic drive(input logic s, input logic f, input logic r, input logic [31:0] rpc);
    exp_t e;
    stall       = s;
    flush       = f;
    redirect    = r;
    redirect_pc = rpc;
    if (f || r) begin
      m_v = 1'b0; m_ins = '0; m_ipc = '0; m_ip4 = '0;
    end else if (!s) begin
      m_v = 1'b1; m_ins = memf(m_pc[9:2]); m_ipc = m_pc; m_ip4 = m_pc + 32'd4;
    end
    if (!f && !r && !s) m_fc = m_fc + 32'd1;
    if (s && !r) m_sc = m_sc + 32'd1;
    if (f || r) m_flc = m_flc + 32'd1;
    if (r) m_pc = {rpc[31:2], 2'b00};
    else if (!s) m_pc = m_pc + 32'd4;
    e.pc = m_pc; e.v = m_v; e.ins = m_ins; e.ipc = m_ipc; e.ip4 = m_ip4;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = '0;
    model_reset();
    #12;
    checks++; if (pc !== RPC) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, RPC); end
    checks++; if (if_id_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", if_id_valid); end
    checks++; if (if_id_instr !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=0", if_id_instr); end
    checks++; if (if_id_pc !== 32'h0) begin failures++; $display("FAIL reset_ifid_pc got=%h exp=0", if_id_pc); end
    checks++; if (if_id_pc_plus4 !== 32'h0) begin failures++; $display("FAIL reset_pc4 got=%h exp=0", if_id_pc_plus4); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      checks++; if (addr !== 8'(8'h10 + i)) begin failures++; $display("FAIL seq_addr got=%h exp=%h", addr, 8'(8'h10 + i)); end
      drive(1'b0, 1'b0, 1'b0, '0);
      e = q.pop_front();
      checks++; if (if_id_pc !== RPC + 32'(4 * i)) begin failures++; $display("FAIL seq_ifid_pc got=%h exp=%h", if_id_pc, RPC + 32'(4 * i)); end
      checks++; if (if_id_valid !== 1'b1) begin failures++; $display("FAIL seq_valid got=%b exp=1", if_id_valid); end
      checks++; if (if_id_pc_plus4 !== e.ip4) begin failures++; $display("FAIL seq_pc4 got=%h exp=%h", if_id_pc_plus4, e.ip4); end
      checks++; if (if_id_instr !== e.ins) begin failures++; $display("FAIL seq_instr got=%h exp=%h", if_id_instr, e.ins); end
      checks++; if (pc !== e.pc) begin failures++; $display("FAIL seq_pc got=%h exp=%h", pc, e.pc); end
    end
  endtask

  task automatic test_redirect();
    exp_t e;
    drive(1'b0, 1'b0, 1'b1, 32'h20);
    e = q.pop_front();
    checks++; if (pc !== 32'h20) begin failures++; $display("FAIL redir_setup_pc got=%h exp=20", pc); end
    drive(1'b0, 1'b0, 1'b1, 32'h103);
    e = q.pop_front();
    checks++; if (pc !== 32'h100) begin failures++; $display("FAIL redir_pc got=%h exp=100", pc); end
    checks++; if (if_id_valid !== 1'b0) begin failures++; $display("FAIL redir_valid got=%b exp=0", if_id_valid); end
    checks++; if (if_id_instr !== e.ins) begin failures++; $display("FAIL redir_instr got=%h exp=%h", if_id_instr, e.ins); end
    drive(1'b0, 1'b0, 1'b0, '0);
    e = q.pop_front();
    checks++; if (if_id_pc !== 32'h100) begin failures++; $display("FAIL redir_ifid_pc got=%h exp=100", if_id_pc); end
    checks++; if (if_id_valid !== 1'b1) begin failures++; $display("FAIL redir_next_valid got=%b exp=1", if_id_valid); end
    checks++; if (if_id_instr !== e.ins) begin failures++; $display("FAIL redir_next_instr got=%h exp=%h", if_id_instr, e.ins); end
  endtask

  task automatic test_stall();
    exp_t e;
    drive(1'b0, 1'b0, 1'b1, 32'h04);
    e = q.pop_front();
    drive(1'b0, 1'b0, 1'b0, '0);
    e = q.pop_front();
    checks++; if (pc !== 32'h08) begin failures++; $display("FAIL stall_setup_pc got=%h exp=08", pc); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, '0);
      e = q.pop_front();
      checks++; if (pc !== 32'h08) begin failures++; $display("FAIL stall_pc got=%h exp=08", pc); end
      checks++; if (if_id_pc !== 32'h04) begin failures++; $display("FAIL stall_ifid_pc got=%h exp=04", if_id_pc); end
      checks++; if (if_id_instr !== e.ins || if_id_valid !== e.v || if_id_pc_plus4 !== e.ip4) begin
        failures++; $display("FAIL stall_ifid got=%h/%b/%h exp=%h/%b/%h", if_id_instr, if_id_valid, if_id_pc_plus4, e.ins, e.v, e.ip4);
      end
    end
    drive(1'b0, 1'b0, 1'b0, '0);
    e = q.pop_front();
    checks++; if (if_id_pc !== 32'h08 || if_id_valid !== 1'b1) begin failures++; $display("FAIL stall_resume got=%h/%b exp=08/1", if_id_pc, if_id_valid); end
    checks++; if (if_id_instr !== e.ins) begin failures++; $display("FAIL stall_resume_instr got=%h exp=%h", if_id_instr, e.ins); end
  endtask

  task automatic test_stall_redirect();
    exp_t e;
    drive(1'b1, 1'b0, 1'b1, 32'h200);
    e = q.pop_front();
    checks++; if (pc !== 32'h200) begin failures++; $display("FAIL stallredir_pc got=%h exp=200", pc); end
    checks++; if (if_id_valid !== 1'b0 || if_id_pc !== e.ipc) begin failures++; $display("FAIL stallredir_bubble got=%b/%h exp=0/%h", if_id_valid, if_id_pc, e.ipc); end
  endtask

  task automatic test_flush();
    exp_t e;
    drive(1'b0, 1'b0, 1'b0, '0);
    e = q.pop_front();
    drive(1'b1, 1'b1, 1'b0, '0);
    e = q.pop_front();
    checks++; if (pc !== 32'h204) begin failures++; $display("FAIL flushstall_pc got=%h exp=204", pc); end
    checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || if_id_pc_plus4 !== e.ip4) begin
      failures++; $display("FAIL flushstall_bubble got=%b/%h/%h exp=0/0/%h", if_id_valid, if_id_instr, if_id_pc_plus4, e.ip4);
    end
    drive(1'b0, 1'b1, 1'b0, '0);
    e = q.pop_front();
    checks++; if (pc !== 32'h208) begin failures++; $display("FAIL flush_pc got=%h exp=208", pc); end
    checks++; if (if_id_valid !== e.v) begin failures++; $display("FAIL flush_valid got=%b exp=%b", if_id_valid, e.v); end
    drive(1'b0, 1'b0, 1'b0, '0);
    e = q.pop_front();
    checks++; if (if_id_pc !== 32'h208 || if_id_instr !== e.ins) begin failures++; $display("FAIL flush_resume got=%h/%h exp=208/%h", if_id_pc, if_id_instr, e.ins); end
  endtask

  task automatic test_wrap();
    exp_t e;
    drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    e = q.pop_front();
    checks++; if (addr !== 8'hFF) begin failures++; $display("FAIL wrap_addr got=%h exp=ff", addr); end
    drive(1'b0, 1'b0, 1'b0, '0);
    e = q.pop_front();
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL wrap_pc got=%h exp=0", pc); end
    checks++; if (if_id_pc_plus4 !== 32'h0) begin failures++; $display("FAIL wrap_pc4 got=%h exp=0", if_id_pc_plus4); end
    checks++; if (if_id_pc !== 32'hFFFF_FFFC || if_id_instr !== e.ins) begin failures++; $display("FAIL wrap_ifid got=%h/%h exp=fffffffc/%h", if_id_pc, if_id_instr, e.ins); end
  endtask

  task automatic test_async_reset();
    drive(1'b0, 1'b0, 1'b0, '0);
    void'(q.pop_front());
    stall = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (pc !== RPC) begin failures++; $display("FAIL async_pc got=%h exp=%h", pc, RPC); end
    checks++; if (if_id_valid !== 1'b0) begin failures++; $display("FAIL async_valid got=%b exp=0", if_id_valid); end
    checks++; if (if_id_pc !== 32'h0 || if_id_instr !== 32'h0) begin failures++; $display("FAIL async_ifid got=%h/%h exp=0/0", if_id_pc, if_id_instr); end
    model_reset();
    #1;
    stall = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_perf();
    exp_t e;
`ifdef FETCH_PERF_CNT_EN
    checks++; if (fetch_cnt !== 32'd0 || stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      failures++; $display("FAIL perf_reset got=%0d/%0d/%0d exp=0/0/0", fetch_cnt, stall_cnt, flush_cnt);
    end
`endif
    for (int i = 0; i < 8; i++) begin
      drive(i == 5 || i == 6, 1'b0, i == 7, 32'h300);
      e = q.pop_front();
      checks++; if (pc !== e.pc) begin failures++; $display("FAIL perf_pc got=%h exp=%h", pc, e.pc); end
    end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (fetch_cnt !== 32'd5 || fetch_cnt !== m_fc) begin failures++; $display("FAIL perf_fetch got=%0d exp=5", fetch_cnt); end
    checks++; if (stall_cnt !== 32'd2 || stall_cnt !== m_sc) begin failures++; $display("FAIL perf_stall got=%0d exp=2", stall_cnt); end
    checks++; if (flush_cnt !== 32'd1 || flush_cnt !== m_flc) begin failures++; $display("FAIL perf_flush got=%0d exp=1", flush_cnt); end
`endif
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_sequential();
    test_redirect();
    test_stall();
    test_stall_redirect();
    test_flush();
    test_wrap();
    test_async_reset();
    test_perf();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
